uart_program_loader: RTL and testbench

Serial boot loader sitting directly upstream of the RISC-V pipeline CPU's instruction memory. Receives a framed program image on the UART RX pin and assembles little-endian 32-bit words. Writes them sequentially into instruction memory and holds the CPU stalled until the image is complete. Reports success or failure with single-cycle status pulses.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/uart_program_loader_if.sv | 12 +
 rtl/uart_rx_byte.sv | 105 ++++++++++
 rtl/uart_program_loader.sv | 143 ++++++++++++++
 tb/tb_uart_program_loader.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared loader definitions: FSM state encodings, the frame sync byte and the
// running checksum helper used by the serial program loader.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  // Modulo-256 accumulation of one data byte into the frame checksum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data_byte);
    return acc + data_byte;
  endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// Instruction-memory write port driven by the loader (master) and
// consumed by the instruction memory (slave).
interface uart_program_loader_if #(
  parameter int ADDR_W = 7
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-FF input synchroniser, mid-start glitch
// rejection and a one-cycle byte-valid / framing-error pulse.
module uart_rx_byte
  import riscv_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_r;
  logic             prev_r;
  rx_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_r;
  logic [7:0]       shift_r;
  logic [7:0]       data_r;
  logic             valid_r;
  logic             frame_err_r;
  logic             line_s;

  assign line_s = sync_r[1];

  // Synchroniser, bit timing and deserialisation.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r      <= 2'b11;
      prev_r      <= 1'b1;
      state_r     <= RX_IDLE;
      cnt_r       <= CNT_ZERO;
      bit_r       <= 3'd0;
      shift_r     <= 8'h00;
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      sync_r      <= {sync_r[0], rx};
      prev_r      <= line_s;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          if (prev_r && !line_s) begin
            state_r <= RX_START;
            cnt_r   <= CNT_ZERO;
          end
        end
        RX_START: begin
          // A line already back high at mid-start is a glitch, not a byte.
          if (cnt_r == HALF_LAST) begin
            cnt_r   <= CNT_ZERO;
            bit_r   <= 3'd0;
            state_r <= line_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= CNT_ZERO;
            shift_r <= {line_s, shift_r[7:1]};
            if (bit_r == 3'd7) begin
              state_r <= RX_STOP;
            end else begin
              bit_r <= bit_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= CNT_ZERO;
            state_r <= RX_IDLE;
            if (line_s) begin
              valid_r <= 1'b1;
              data_r  <= shift_r;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end

  assign rx_data      = data_r;
  assign rx_valid     = valid_r;
  assign rx_frame_err = frame_err_r;

endmodule

// File: rtl/uart_program_loader.sv
// Serial boot loader: parses A5/length/data/checksum frames from the UART and
// writes little-endian words into instruction memory while holding the CPU.
module uart_program_loader
  import riscv_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 434,
  parameter int INSTR_MEM_DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   uart_rx,
  uart_program_loader_if.master  mem_if,
  output logic                   cpu_hold,
  output logic                   load_done,
  output logic                   load_err
);

  localparam int ADDR_W = $clog2(INSTR_MEM_DEPTH);
  localparam logic [8:0] DEPTH_LIMIT = 9'(INSTR_MEM_DEPTH);

  logic [7:0]        rx_data_s;
  logic              rx_valid_s;
  logic              rx_frame_err_s;

  loader_state_t     state_r;
  logic [7:0]        len_r;
  logic [7:0]        word_cnt_r;
  logic [1:0]        byte_idx_r;
  logic [23:0]       word_r;
  logic [7:0]        csum_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              cpu_hold_r;
  logic              load_done_r;
  logic              load_err_r;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .rx           (uart_rx),
    .rx_data      (rx_data_s),
    .rx_valid     (rx_valid_s),
    .rx_frame_err (rx_frame_err_s)
  );

  // Loader FSM with word assembly, address counter and checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      len_r       <= 8'd0;
      word_cnt_r  <= 8'd0;
      byte_idx_r  <= 2'd0;
      word_r      <= 24'd0;
      csum_r      <= 8'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 32'd0;
      cpu_hold_r  <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      mem_we_r    <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rx_valid_s && (rx_data_s == LOADER_SYNC_BYTE)) begin
            state_r    <= LEN;
            cpu_hold_r <= 1'b1;
          end
        end
        LEN: begin
          if (rx_frame_err_s) begin
            load_err_r <= 1'b1;
            cpu_hold_r <= 1'b0;
            state_r    <= IDLE;
          end else if (rx_valid_s) begin
            if ((rx_data_s == 8'd0) || ({1'b0, rx_data_s} > DEPTH_LIMIT)) begin
              load_err_r <= 1'b1;
              cpu_hold_r <= 1'b0;
              state_r    <= IDLE;
            end else begin
              len_r      <= rx_data_s;
              word_cnt_r <= 8'd0;
              byte_idx_r <= 2'd0;
              csum_r     <= 8'd0;
              state_r    <= DATA;
            end
          end
        end
        DATA: begin
          if (rx_frame_err_s) begin
            load_err_r <= 1'b1;
            cpu_hold_r <= 1'b0;
            state_r    <= IDLE;
          end else if (rx_valid_s) begin
            // Bytes shift in from the top, so byte k lands at [8k+7:8k] once the word is complete.
            csum_r     <= csum_add(csum_r, rx_data_s);
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              mem_we_r    <= 1'b1;
              mem_addr_r  <= word_cnt_r[ADDR_W-1:0];
              mem_wdata_r <= {rx_data_s, word_r};
              word_cnt_r  <= word_cnt_r + 8'd1;
              if (word_cnt_r == (len_r - 8'd1)) begin
                state_r <= CSUM;
              end
            end else begin
              word_r <= {rx_data_s, word_r[23:8]};
            end
          end
        end
        CSUM: begin
          if (rx_frame_err_s) begin
            load_err_r <= 1'b1;
            cpu_hold_r <= 1'b0;
            state_r    <= IDLE;
          end else if (rx_valid_s) begin
            load_done_r <= (rx_data_s == csum_r);
            load_err_r  <= (rx_data_s != csum_r);
            cpu_hold_r  <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          cpu_hold_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign mem_if.mem_we    = mem_we_r;
  assign mem_if.mem_addr  = mem_addr_r;
  assign mem_if.mem_wdata = mem_wdata_r;
  assign cpu_hold         = cpu_hold_r;
  assign load_done        = load_done_r;
  assign load_err         = load_err_r;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for the UART program loader: directed frames push expected
// memory writes and status pulses; a monitor pops and compares each DUT event.
module tb_uart_program_loader;

  localparam int CPB    = 8;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  localparam logic [1:0] K_WR   = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  typedef struct {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic cpu_hold, load_done, load_err;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  int         checks = 0;
  int         errors = 0;

  uart_program_loader_if #(.ADDR_W(ADDR_W)) mem_if ();

  uart_program_loader #(
    .CLKS_PER_BIT    (CPB),
    .INSTR_MEM_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .mem_if    (mem_if),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Monitor: every write or status pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_if.mem_we || load_done || load_err) begin
      logic [1:0] kind;
      exp_t e;
      kind = mem_if.mem_we ? K_WR : (load_done ? K_DONE : K_ERR);
      checks++;
      if (load_done && load_err) begin
        errors++;
        $display("FAIL status_exclusive: load_done=%0b load_err=%0b, required not both", load_done, load_err);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: kind=%0d addr=%0d data=%08h, required no event", kind, mem_if.mem_addr, mem_if.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || (kind == K_WR && (e.addr != mem_if.mem_addr || e.data != mem_if.mem_wdata))) begin
          errors++;
          $display("FAIL event: got kind=%0d addr=%0d data=%08h, required kind=%0d addr=%0d data=%08h",
                   kind, mem_if.mem_addr, mem_if.mem_wdata, e.kind, e.addr, e.data);
        end
      end
      checks++;
      if (cpu_hold != (kind == K_WR)) begin
        errors++;
        $display("FAIL hold_at_event: cpu_hold=%0b, required %0b", cpu_hold, (kind == K_WR));
      end
    end
  end

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = K_WR; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input logic [1:0] k);
    exp_t e;
    e.kind = k; e.addr = '0; e.data = 32'd0;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  // Sends the queued bytes back-to-back, no idle time between frames' bits.
  task automatic send_tx();
    while (tx_q.size() != 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  task automatic check_hold(input string name, input logic req);
    checks++;
    if (cpu_hold != req) begin
      errors++;
      $display("FAIL %s: cpu_hold=%0b, required %0b", name, cpu_hold, req);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (mem_if.mem_we || load_done || load_err || cpu_hold || mem_if.mem_addr != '0 || mem_if.mem_wdata != 32'd0) begin
      errors++;
      $display("FAIL %s: we=%0b done=%0b err=%0b hold=%0b addr=%0d data=%08h, required all 0",
               name, mem_if.mem_we, load_done, load_err, cpu_hold, mem_if.mem_addr, mem_if.mem_wdata);
    end
  endtask

  // Lets the line idle, then requires the scoreboard to have drained within a bound.
  task automatic drain(input string name);
    int n;
    repeat (16) @(negedge clk);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    // Good image bytes: 0x00500093, 0x00108113; checksum 93+00+50+00+13+81+10+00 = 0x187 -> 0x87.
    repeat (4) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");

    // Noise: short glitch and non-sync bytes while idle.
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    tx_q = '{8'h00, 8'hFF};
    send_tx();
    drain("noise");
    check_hold("noise_hold", 1'b0);
    check_all_zero("noise_outputs");

    // Good load.
    expect_wr(7'd0, 32'h00500093);
    expect_wr(7'd1, 32'h00108113);
    expect_ev(K_DONE);
    send_byte(8'hA5, 1'b1);
    repeat (8) @(negedge clk);
    check_hold("hold_after_sync", 1'b1);
    tx_q = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h87};
    send_tx();
    drain("good_load");
    check_hold("hold_after_done", 1'b0);

    // Bad checksum.
    expect_wr(7'd0, 32'h00500093);
    expect_wr(7'd1, 32'h00108113);
    expect_ev(K_ERR);
    tx_q = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h88};
    send_tx();
    drain("bad_csum");
    check_hold("hold_after_bad_csum", 1'b0);

    // Length zero and length one past the memory depth.
    expect_ev(K_ERR);
    tx_q = '{8'hA5, 8'h00};
    send_tx();
    drain("len_zero");
    check_hold("hold_after_len_zero", 1'b0);
    expect_ev(K_ERR);
    tx_q = '{8'hA5, 8'h81};
    send_tx();
    drain("len_over");
    check_hold("hold_after_len_over", 1'b0);

    // Framing error on the second data byte, then a one-word recovery frame (csum 13+81+10+00 = 0xA4).
    expect_ev(K_ERR);
    tx_q = '{8'hA5, 8'h01, 8'h93};
    send_tx();
    send_byte(8'h00, 1'b0);
    drain("frame_err");
    check_hold("hold_after_frame_err", 1'b0);
    expect_wr(7'd0, 32'h00108113);
    expect_ev(K_DONE);
    tx_q = '{8'hA5, 8'h01, 8'h13, 8'h81, 8'h10, 8'h00, 8'hA4};
    send_tx();
    drain("recovery");

    // Reset after five data bytes: one word written, then a clean abort.
    expect_wr(7'd0, 32'h00500093);
    tx_q = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
    send_tx();
    repeat (8) @(negedge clk);
    check_hold("hold_mid_load", 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset_mid_load");
    drain("mid_load_write");
    expect_wr(7'd0, 32'h00500093);
    expect_wr(7'd1, 32'h00108113);
    expect_ev(K_DONE);
    tx_q = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h87};
    send_tx();
    drain("after_reset_load");
    check_hold("hold_final", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
